// File: rtl/grid_frame_buffer.sv
// Double-buffered 8x8 board store: game logic edits a back buffer, and a commit
// publishes it to the registered front buffer (Row1..Row8) on a frame_sync edge.
module grid_frame_buffer #(
  parameter logic [4:0] INIT_CODE  = 5'd0,
  parameter logic [4:0] CLEAR_CODE = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_row,
  input  logic [2:0]  wr_col,
  input  logic [4:0]  wr_code,
  input  logic        clear_req,
  input  logic        commit_req,
  input  logic        frame_sync,
  output logic        busy,
  output logic        commit_pending,
  output logic [7:0]  commit_count,
  output logic [39:0] Row1,
  output logic [39:0] Row2,
  output logic [39:0] Row3,
  output logic [39:0] Row4,
  output logic [39:0] Row5,
  output logic [39:0] Row6,
  output logic [39:0] Row7,
  output logic [39:0] Row8
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    WAIT_SYNC = 2'd2
  } state_t;

  localparam logic [39:0] INIT_ROW  = {8{INIT_CODE}};
  localparam logic [39:0] CLEAR_ROW = {8{CLEAR_CODE}};

  state_t            state_q, state_d;
  logic [2:0]        clr_row_q, clr_row_d;
  logic              latch_q, latch_d;
  logic [7:0]        count_q, count_d;
  logic [7:0][39:0]  back_q, back_d;
  logic [7:0][39:0]  front_q, front_d;
  logic [5:0]        col_lsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clr_row_q <= 3'd0;
      latch_q   <= 1'b0;
      count_q   <= 8'd0;
      back_q    <= {8{INIT_ROW}};
      front_q   <= {8{INIT_ROW}};
    end else begin
      state_q   <= state_d;
      clr_row_q <= clr_row_d;
      latch_q   <= latch_d;
      count_q   <= count_d;
      back_q    <= back_d;
      front_q   <= front_d;
    end
  end

  // A commit request seen during a clear is remembered so it fires once the clear ends.
  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    latch_d   = latch_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_row_d = 3'd0;
          latch_d   = commit_req;
        end else if (commit_req) begin
          state_d = WAIT_SYNC;
        end
      end
      CLEAR: begin
        clr_row_d = clr_row_q + 3'd1;
        latch_d   = latch_q | commit_req;
        if (clr_row_q == 3'd7) begin
          state_d = (latch_q || commit_req) ? WAIT_SYNC : IDLE;
        end
      end
      WAIT_SYNC: begin
        if (frame_sync) begin
          state_d = IDLE;
          latch_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        latch_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ready       = (state_q == IDLE);
    busy           = (state_q != IDLE);
    commit_pending = (state_q == WAIT_SYNC) || ((state_q == CLEAR) && latch_q);
  end

  // Buffer datapath: writes only in IDLE, one cleared row per CLEAR cycle, whole-board copy on sync.
  always_comb begin
    back_d  = back_q;
    front_d = front_q;
    count_d = count_q;
    col_lsb = 6'(wr_col) * 6'd5;
    if (wr_valid && (state_q == IDLE)) begin
      back_d[wr_row][col_lsb +: 5] = wr_code;
    end
    if (state_q == CLEAR) begin
      back_d[clr_row_q] = CLEAR_ROW;
    end
    if ((state_q == WAIT_SYNC) && frame_sync) begin
      front_d = back_q;
      count_d = count_q + 8'd1;
    end
  end

  assign commit_count = count_q;
  assign Row1 = front_q[0];
  assign Row2 = front_q[1];
  assign Row3 = front_q[2];
  assign Row4 = front_q[3];
  assign Row5 = front_q[4];
  assign Row6 = front_q[5];
  assign Row7 = front_q[6];
  assign Row8 = front_q[7];

endmodule

// File: doc/grid_frame_buffer.md
Name: grid_frame_buffer

Overview:
- Game-side board store that sits directly upstream of screen_top and drives its Row1..Row8 inputs.
- Game logic writes individual cells into a back buffer. It can bulk-clear the buffer and request a commit.
- A commit copies the back buffer into the front buffer in one cycle, only when the display signals a safe frame boundary. The LCD never sees a half-updated board.

Parameters:
- INIT_CODE, 5'd0, value loaded into every cell of both buffers on reset.
- CLEAR_CODE, 5'd0, value written into every back-buffer cell by a clear operation.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock, asynchronous, active-high.
- wr_valid  input  1  cell write request.
- wr_ready  output  1  block can accept a cell write this cycle.
- wr_row  input  3  target row, 0..7 (0 maps to Row1).
- wr_col  input  3  target column, 0..7.
- wr_code  input  5  cell code.
- clear_req  input  1  single-cycle request to fill the back buffer with CLEAR_CODE.
- commit_req  input  1  single-cycle request to publish the back buffer.
- frame_sync  input  1  display-safe strobe; tie to 1 for immediate commits.
- busy  output  1  a clear is in progress or a commit is pending.
- commit_pending  output  1  a commit has been requested and is not yet done.
- commit_count  output  8  number of completed commits, wraps 255->0.
- Row1..Row8  output  40 each  front-buffer rows, registered.

Behaviour:
- Cell packing: column c occupies bits [5c+4:5c] of its row. Column 0 is in the LSBs.
- Reset (async, immediate, also mid-operation):
  - Both buffers go to INIT_CODE in all cells.
  - state=IDLE; the clear row counter goes to 0; the latched commit request is cleared.
  - commit_count=0, busy=0, commit_pending=0.
  - wr_ready=1 after reset deasserts.
- States: IDLE, CLEAR, WAIT_SYNC.
- wr_ready = (state==IDLE), combinational from state only.
- A write handshake (wr_valid & wr_ready) updates back[wr_row][wr_col] at the clock edge. Outside IDLE, wr_valid is ignored and nothing is written.
- IDLE, priority clear_req > commit_req:
  - clear_req -> CLEAR with row counter 0. If commit_req is high in the same cycle, it is latched.
  - commit_req alone -> WAIT_SYNC.
  - A write accepted in the same cycle as clear_req is overwritten by the clear.
  - A write accepted in the same cycle as commit_req is included in that commit.
- CLEAR:
  - Each cycle, back row[counter] is set to all CLEAR_CODE and the counter increments. This takes exactly 8 cycles: rows 0..7.
  - On the row-7 cycle: go to WAIT_SYNC if a commit is latched (or commit_req is high that cycle), otherwise go to IDLE.
  - commit_req at any time during CLEAR is latched.
  - clear_req during CLEAR is ignored.
- WAIT_SYNC:
  - When frame_sync is sampled high, all 320 bits of back are copied into front at that edge.
  - commit_count increments, the latch clears, and state goes to IDLE.
  - clear_req and commit_req are ignored here; the pending commit already covers the request.
- Latency: commit_req in IDLE at cycle N, with frame_sync held high, gives new Row outputs at cycle N+2. The cycle N+1 edge enters WAIT_SYNC and the next edge copies.
- Outputs:
  - commit_pending=1 in WAIT_SYNC, and in CLEAR while a commit is latched.
  - busy=1 whenever state!=IDLE.
- The back buffer persists after a commit. Later writes are incremental edits.
- Row1..Row8 change only on a commit edge or on reset. They are stable for all other cycles.
- If frame_sync never arrives, the block stays in WAIT_SYNC indefinitely with wr_ready=0. The system owner must guarantee that frame_sync toggles.

Test Plan:
1. Reset with INIT_CODE=5'd3 -> all Row outputs read 40'h18C6318C63 (eight fields of 3); wr_ready=1, busy=0, commit_count=0.
2. Write (row 2, col 5, code 5'h1F), then commit_req with frame_sync=1 -> Row3[29:25]=5'h1F and all other fields unchanged. Row outputs update 2 cycles after commit_req; commit_count=1.
3. Write row 0, col 0, code 7, then commit_req with frame_sync=0 for 10 cycles -> Row1 unchanged, commit_pending=1, wr_ready=0, and a write attempted meanwhile is dropped. Pulse frame_sync -> Row1[4:0]=7 on the next edge.
4. clear_req and commit_req in the same IDLE cycle, CLEAR_CODE=5'd9 -> busy for 8 CLEAR cycles, then WAIT_SYNC. All rows become 40'h4A5294A529 after sync; commit_count increments by exactly 1.
5. Assert rst during CLEAR cycle 4 -> outputs immediately return to INIT_CODE, state=IDLE, no commit occurs, and commit_count=0.
6. Perform 256 commits -> commit_count wraps to 0. A write in the same cycle as clear_req -> that cell reads CLEAR_CODE after the next commit.
